// File: rtl/fault_mem_if.sv
// fault_mem_if: access and fault-configuration bus of the fault-injecting SRAM model.
// master = MBIST engine / test driver, slave = fault_mem_multi.
interface fault_mem_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned SLOT_W     = 2,
    parameter int unsigned BIT_W      = 3
);
    // Memory access, one access (read or write) per cycle
    logic                  write_read;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;

    // Fault slot programming
    logic                  cfg_we;
    logic [SLOT_W-1:0]     cfg_idx;
    logic                  cfg_en;
    logic [2:0]            cfg_type;
    logic [ADDR_WIDTH-1:0] cfg_vaddr;
    logic [BIT_W-1:0]      cfg_vbit;
    logic [ADDR_WIDTH-1:0] cfg_aaddr;
    logic [BIT_W-1:0]      cfg_abit;
    logic                  cfg_val;

    modport master (
        output write_read, address, wdata,
        output cfg_we, cfg_idx, cfg_en, cfg_type, cfg_vaddr, cfg_vbit, cfg_aaddr, cfg_abit,
        output cfg_val,
        input  rdata, rvalid
    );

    modport slave (
        input  write_read, address, wdata,
        input  cfg_we, cfg_idx, cfg_en, cfg_type, cfg_vaddr, cfg_vbit, cfg_aaddr, cfg_abit,
        input  cfg_val,
        output rdata, rvalid
    );
endinterface

// File: rtl/fault_mem_multi.sv
// fault_mem_multi: single-port SRAM model with NUM_FAULTS runtime-programmable fault slots
// (stuck-at, transition, idempotent coupling, neighbourhood-pattern-sensitive).
// Reads have a two-edge latency; writes commit at the edge they are sampled.
// Optional build macro FAULT_MEM_STATS_EN adds the saturating fault_hits output.
module fault_mem_multi #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned NUM_FAULTS = 4,
    parameter int unsigned SLOT_W     = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1,
    parameter int unsigned BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic       clk,
    input  logic       rst_n,
    fault_mem_if.slave bus
`ifdef FAULT_MEM_STATS_EN
    ,
    output logic [15:0] fault_hits
`endif
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [2:0] T_SA0   = 3'd0;
    localparam logic [2:0] T_SA1   = 3'd1;
    localparam logic [2:0] T_TF_UP = 3'd2;
    localparam logic [2:0] T_TF_DN = 3'd3;
    localparam logic [2:0] T_CFID  = 3'd4;
    localparam logic [2:0] T_NPSF  = 3'd5;

    // Storage array, deliberately not reset
    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_mem;

    // Fault slot table
    logic [NUM_FAULTS-1:0]                 r_en;
    logic [NUM_FAULTS-1:0][2:0]            r_type;
    logic [NUM_FAULTS-1:0][ADDR_WIDTH-1:0] r_vaddr;
    logic [NUM_FAULTS-1:0][BIT_W-1:0]      r_vbit;
    logic [NUM_FAULTS-1:0][ADDR_WIDTH-1:0] r_aaddr;
    logic [NUM_FAULTS-1:0][BIT_W-1:0]      r_abit;
    logic [NUM_FAULTS-1:0]                 r_val;

    // Read pipeline
    logic [DATA_WIDTH-1:0] r_stage;
    logic                  r_pend;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;

    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_nb_lo;
    logic [DATA_WIDTH-1:0] w_nb_hi;
    logic [ADDR_WIDTH-1:0] w_addr_lo;
    logic [ADDR_WIDTH-1:0] w_addr_hi;
    logic [DATA_WIDTH-1:0] w_cur;
    logic [NUM_FAULTS-1:0] w_cf_side;
    logic [DATA_WIDTH-1:0] w_rd;

    // Neighbour indices wrap naturally in ADDR_WIDTH bits
    assign w_addr_lo = bus.address - ADDR_WIDTH'(1);
    assign w_addr_hi = bus.address + ADDR_WIDTH'(1);
    assign w_old     = r_mem[bus.address];
    assign w_nb_lo   = r_mem[w_addr_lo];
    assign w_nb_hi   = r_mem[w_addr_hi];

    // Write word after applying every enabled slot in ascending order; later slots override
    always_comb begin
        w_cur     = bus.wdata;
        w_cf_side = '0;
        for (int unsigned s = 0; s < NUM_FAULTS; s++) begin
            if (r_en[s]) begin
                case (r_type[s])
                    T_SA0: begin
                        if (r_vaddr[s] == bus.address) w_cur[r_vbit[s]] = 1'b0;
                    end
                    T_SA1: begin
                        if (r_vaddr[s] == bus.address) w_cur[r_vbit[s]] = 1'b1;
                    end
                    T_TF_UP: begin
                        if (r_vaddr[s] == bus.address && !w_old[r_vbit[s]] &&
                            w_cur[r_vbit[s]]) begin
                            w_cur[r_vbit[s]] = 1'b0;
                        end
                    end
                    T_TF_DN: begin
                        if (r_vaddr[s] == bus.address && w_old[r_vbit[s]] &&
                            !w_cur[r_vbit[s]]) begin
                            w_cur[r_vbit[s]] = 1'b1;
                        end
                    end
                    T_CFID: begin
                        // Aggressor rising transition; a victim in the written word is
                        // overridden here, any other victim word gets a side write
                        if (r_aaddr[s] == bus.address && !w_old[r_abit[s]] &&
                            w_cur[r_abit[s]]) begin
                            if (r_vaddr[s] == bus.address) begin
                                w_cur[r_vbit[s]] = r_val[s];
                            end else begin
                                w_cf_side[s] = 1'b1;
                            end
                        end
                    end
                    T_NPSF: begin
                        if (r_vaddr[s] == bus.address && w_nb_lo[r_vbit[s]] == r_val[s] &&
                            w_nb_hi[r_vbit[s]] == r_val[s]) begin
                            w_cur[r_vbit[s]] = ~r_val[s];
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Read word with stuck-at faults overlaid (covers never-written or preloaded cells)
    always_comb begin
        w_rd = w_old;
        for (int unsigned s = 0; s < NUM_FAULTS; s++) begin
            if (r_en[s] && r_vaddr[s] == bus.address) begin
                if (r_type[s] == T_SA0) w_rd[r_vbit[s]] = 1'b0;
                if (r_type[s] == T_SA1) w_rd[r_vbit[s]] = 1'b1;
            end
        end
    end

    // Array update: main write plus coupling side writes, later slot wins on a shared bit
    always_ff @(posedge clk) begin
        if (bus.write_read) begin
            r_mem[bus.address] <= w_cur;
            for (int unsigned s = 0; s < NUM_FAULTS; s++) begin
                if (w_cf_side[s]) r_mem[r_vaddr[s]][r_vbit[s]] <= r_val[s];
            end
        end
    end

    // Slot table programming; a same-cycle access still sees the old table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en    <= '0;
            r_type  <= '0;
            r_vaddr <= '0;
            r_vbit  <= '0;
            r_aaddr <= '0;
            r_abit  <= '0;
            r_val   <= '0;
        end else if (bus.cfg_we && (32'(bus.cfg_idx) < NUM_FAULTS)) begin
            r_en[bus.cfg_idx]    <= bus.cfg_en;
            r_type[bus.cfg_idx]  <= bus.cfg_type;
            r_vaddr[bus.cfg_idx] <= bus.cfg_vaddr;
            r_vbit[bus.cfg_idx]  <= bus.cfg_vbit;
            r_aaddr[bus.cfg_idx] <= bus.cfg_aaddr;
            r_abit[bus.cfg_idx]  <= bus.cfg_abit;
            r_val[bus.cfg_idx]   <= bus.cfg_val;
        end
    end

    // Two-edge read pipeline: capture at sample edge, present one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage  <= '0;
            r_pend   <= 1'b0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_pend <= ~bus.write_read;
            if (!bus.write_read) r_stage <= w_rd;
            r_rvalid <= r_pend;
            if (r_pend) r_rdata <= r_stage;
        end
    end

    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;

`ifdef FAULT_MEM_STATS_EN
    logic        w_hit;
    logic [15:0] r_hits;

    // Any slot changed a stored bit (main or side write) or a returned read bit
    always_comb begin
        w_hit = 1'b0;
        if (bus.write_read) begin
            if (w_cur != bus.wdata) w_hit = 1'b1;
            for (int unsigned s = 0; s < NUM_FAULTS; s++) begin
                if (w_cf_side[s] && r_mem[r_vaddr[s]][r_vbit[s]] != r_val[s]) w_hit = 1'b1;
            end
        end else if (w_rd != w_old) begin
            w_hit = 1'b1;
        end
    end

    // Saturating hit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hits <= '0;
        end else if (w_hit && r_hits != 16'hFFFF) begin
            r_hits <= r_hits + 16'd1;
        end
    end

    assign fault_hits = r_hits;
`endif
endmodule

// File: tb/tb_fault_mem_multi.sv
// tb_fault_mem_multi: directed fault scenarios plus randomized traffic checked against
// a word/bit-level behavioural model of the fault rules.
module tb_fault_mem_multi;
    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int NF    = 4;
    localparam int SW    = 2;
    localparam int BW    = 3;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fault_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLOT_W(SW), .BIT_W(BW)) bus ();

`ifdef FAULT_MEM_STATS_EN
    logic [15:0] fault_hits;
`endif

    fault_mem_multi #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_FAULTS(NF), .SLOT_W(SW), .BIT_W(BW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FAULT_MEM_STATS_EN
        ,
        .fault_hits (fault_hits)
`endif
    );

    typedef struct {
        bit           en;
        logic [2:0]   typ;
        logic [AW-1:0] va;
        logic [BW-1:0] vb;
        logic [AW-1:0] aa;
        logic [BW-1:0] ab;
        bit           val;
    } slot_t;

    slot_t         sl [NF];
    logic [DW-1:0] mm [DEPTH];
    bit            m_pend;
    logic [DW-1:0] m_stage;
    logic [DW-1:0] m_rdata;
    bit            m_rvalid;
    bit            chk_on = 1'b0;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: DUT outputs against the model on every falling edge
    always @(negedge clk) begin
        if (chk_on) begin
            chk("rvalid", {31'd0, bus.rvalid}, {31'd0, m_rvalid});
            chk("rdata", {24'd0, bus.rdata}, {24'd0, m_rdata});
        end
    end

    function automatic logic [AW-1:0] win();
        return AW'(60 + $urandom_range(0, 7));
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = mm[a];
        for (int s = 0; s < NF; s++) begin
            if (sl[s].en && sl[s].va == a) begin
                if (sl[s].typ == 3'd0) v[sl[s].vb] = 1'b0;
                else if (sl[s].typ == 3'd1) v[sl[s].vb] = 1'b1;
            end
        end
        return v;
    endfunction

    task automatic m_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] old;
        logic [DW-1:0] v;
        logic [AW-1:0] am1;
        logic [AW-1:0] ap1;
        bit            side [NF];
        old = mm[a];
        v   = d;
        am1 = a - AW'(1);
        ap1 = a + AW'(1);
        for (int s = 0; s < NF; s++) begin
            side[s] = 1'b0;
            if (sl[s].en) begin
                case (sl[s].typ)
                    3'd0: if (sl[s].va == a) v[sl[s].vb] = 1'b0;
                    3'd1: if (sl[s].va == a) v[sl[s].vb] = 1'b1;
                    3'd2: if (sl[s].va == a && v[sl[s].vb] && !old[sl[s].vb]) v[sl[s].vb] = 1'b0;
                    3'd3: if (sl[s].va == a && !v[sl[s].vb] && old[sl[s].vb]) v[sl[s].vb] = 1'b1;
                    3'd4: begin
                        if (sl[s].aa == a && !old[sl[s].ab] && v[sl[s].ab]) begin
                            if (sl[s].va == a) v[sl[s].vb] = sl[s].val;
                            else side[s] = 1'b1;
                        end
                    end
                    3'd5: begin
                        if (sl[s].va == a && mm[am1][sl[s].vb] == sl[s].val &&
                            mm[ap1][sl[s].vb] == sl[s].val) v[sl[s].vb] = ~sl[s].val;
                    end
                    default: begin
                    end
                endcase
            end
        end
        mm[a] = v;
        for (int s = 0; s < NF; s++) begin
            if (side[s]) mm[sl[s].va][sl[s].vb] = sl[s].val;
        end
    endtask

    task automatic model_reset();
        m_pend   = 1'b0;
        m_stage  = '0;
        m_rdata  = '0;
        m_rvalid = 1'b0;
        for (int s = 0; s < NF; s++) sl[s].en = 1'b0;
    endtask

    // One clock: the model consumes the inputs the DUT sampled at this edge
    task automatic cyc();
        @(posedge clk);
        #1;
        if (rst_n) begin
            m_rvalid = m_pend;
            if (m_pend) m_rdata = m_stage;
            if (!bus.write_read) begin
                m_pend  = 1'b1;
                m_stage = m_read(bus.address);
            end else begin
                m_pend = 1'b0;
                m_write(bus.address, bus.wdata);
            end
            if (bus.cfg_we && int'(bus.cfg_idx) < NF) begin
                sl[bus.cfg_idx].en  = bus.cfg_en;
                sl[bus.cfg_idx].typ = bus.cfg_type;
                sl[bus.cfg_idx].va  = bus.cfg_vaddr;
                sl[bus.cfg_idx].vb  = bus.cfg_vbit;
                sl[bus.cfg_idx].aa  = bus.cfg_aaddr;
                sl[bus.cfg_idx].ab  = bus.cfg_abit;
                sl[bus.cfg_idx].val = bus.cfg_val;
            end
        end
    endtask

    task automatic set_op(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.write_read = wr;
        bus.address    = a;
        bus.wdata      = d;
    endtask

    task automatic wr(input int a, input int d);
        set_op(1'b1, AW'(a), DW'(d));
        cyc();
    endtask

    // Read sampled at edge N, result checked just after edge N+1
    task automatic rd_lit(input int a, input int exp, input string name);
        set_op(1'b0, AW'(a), '0);
        cyc();
        cyc();
        chk({name, "_dut"}, {24'd0, bus.rdata}, exp);
        chk({name, "_rvalid"}, {31'd0, bus.rvalid}, 32'd1);
        chk({name, "_model"}, {24'd0, m_rdata}, exp);
    endtask

    task automatic cfg(input int idx, input bit en, input int typ, input int va, input int vb,
                       input int aa, input int ab, input bit val);
        bus.cfg_idx   = SW'(idx);
        bus.cfg_en    = en;
        bus.cfg_type  = 3'(typ);
        bus.cfg_vaddr = AW'(va);
        bus.cfg_vbit  = BW'(vb);
        bus.cfg_aaddr = AW'(aa);
        bus.cfg_abit  = BW'(ab);
        bus.cfg_val   = val;
        bus.cfg_we    = 1'b1;
        set_op(1'b0, '0, '0);
        cyc();
        bus.cfg_we = 1'b0;
    endtask

    task automatic reset_pulse();
        bus.cfg_we = 1'b0;
        set_op(1'b0, win(), '0);
        rst_n = 1'b0;
        model_reset();
        cyc();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.cfg_we = 1'b0;
        bus.cfg_idx = '0;
        bus.cfg_en = 1'b0;
        bus.cfg_type = '0;
        bus.cfg_vaddr = '0;
        bus.cfg_vbit = '0;
        bus.cfg_aaddr = '0;
        bus.cfg_abit = '0;
        bus.cfg_val = 1'b0;
        set_op(1'b0, '0, '0);
        for (int a = 0; a < DEPTH; a++) mm[a] = '0;
        model_reset();
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_rvalid", {31'd0, bus.rvalid}, 32'd0);
        chk("reset_rdata", {24'd0, bus.rdata}, 32'd0);
        chk_on = 1'b1;
        cyc();
        cyc();
        #1;
        rst_n = 1'b1;

        // Fill the whole array so no model cell is undefined
        for (int a = 0; a < DEPTH; a++) wr(a, int'($urandom_range(0, 255)));

        wr(3, 8'h5A);
        rd_lit(3, 8'h5A, "plain");

        cfg(0, 1'b1, 1, 7, 2, 0, 0, 1'b0);
        wr(7, 8'h00);
        rd_lit(7, 8'h04, "sa1");
        cfg(0, 1'b0, 1, 7, 2, 0, 0, 1'b0);
        wr(7, 8'h00);
        rd_lit(7, 8'h00, "sa1_off");

        cfg(1, 1'b1, 2, 9, 0, 0, 0, 1'b0);
        wr(9, 8'h00);
        wr(9, 8'h01);
        rd_lit(9, 8'h00, "tf_up_blocked");
        wr(9, 8'hFF);
        rd_lit(9, 8'hFE, "tf_up_others");

        cfg(2, 1'b1, 4, 5, 7, 4, 1, 1'b1);
        wr(5, 8'h00);
        wr(4, 8'h00);
        wr(4, 8'h02);
        rd_lit(5, 8'h80, "cfid");

        cfg(3, 1'b1, 5, 0, 3, 0, 0, 1'b0);
        wr(63, 8'h00);
        wr(1, 8'h00);
        wr(0, 8'h00);
        rd_lit(0, 8'h08, "npsf_wrap");
        wr(1, 8'h08);
        wr(0, 8'h00);
        rd_lit(0, 8'h00, "npsf_off");

        // Reset between read sample and result edge
        set_op(1'b0, 6'd3, '0);
        cyc();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_rvalid", {31'd0, bus.rvalid}, 32'd0);
        cyc();
        chk("midrst_rvalid_hold", {31'd0, bus.rvalid}, 32'd0);
        chk("midrst_rdata", {24'd0, bus.rdata}, 32'd0);
        #1;
        rst_n = 1'b1;
        wr(9, 8'h00);
        wr(9, 8'h01);
        rd_lit(9, 8'h01, "post_rst_slots_off");
        rd_lit(3, 8'h5A, "post_rst_data_kept");

        // Randomized traffic over a wrapping address window
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) reset_pulse();
            bus.cfg_we    = ($urandom_range(0, 99) < 6);
            bus.cfg_idx   = SW'($urandom_range(0, NF - 1));
            bus.cfg_en    = ($urandom_range(0, 3) != 0);
            bus.cfg_type  = 3'($urandom_range(0, 7));
            bus.cfg_vaddr = win();
            bus.cfg_vbit  = BW'($urandom_range(0, 3));
            bus.cfg_aaddr = win();
            bus.cfg_abit  = BW'($urandom_range(0, 3));
            bus.cfg_val   = 1'($urandom_range(0, 1));
            set_op(1'($urandom_range(0, 1)), win(), DW'($urandom_range(0, 255)));
            cyc();
        end
        bus.cfg_we = 1'b0;
        set_op(1'b0, '0, '0);
        cyc();
        cyc();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
